// File: rtl/seq_detector_param.sv
// Parametrised Mealy detector for an N-bit serial pattern with run-time overlap
// selection, sample enable and a saturating match counter.
module seq_detector_param #(
  parameter int             N       = 5,
  parameter logic [N-1:0]   PATTERN = 5'b11011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  output logic             y,
  output logic [CNT_W-1:0] count
);

  localparam int SW    = $clog2(N);
  localparam int DEPTH = 1 << SW;

  // Longest proper prefix of PATTERN that is a suffix of (first s pattern bits, then b).
  function automatic int kmp_next(input int s, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic bit_v;
    best = 0;
    if (s < N) begin
      for (int k = 1; k <= N - 1; k++) begin
        if (k <= s + 1) begin
          ok = 1'b1;
          for (int j = 0; j < k; j++) begin
            idx   = s + 1 - k + j;
            bit_v = (idx < s) ? PATTERN[N-1-idx] : b;
            if (bit_v != PATTERN[N-1-j]) ok = 1'b0;
          end
          if (ok) best = k;
        end
      end
    end
    return best;
  endfunction

  localparam logic [SW-1:0] LAST_ST = SW'(N - 1);
  localparam logic [SW-1:0] F_ST    = SW'(kmp_next(N - 1, PATTERN[0]));

  logic [SW-1:0] nxt0_tab [DEPTH];
  logic [SW-1:0] nxt1_tab [DEPTH];

  // Unreachable table slots (index >= N) fold to state 0.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tab
    localparam logic [SW-1:0] NXT0 = SW'(kmp_next(gi, 1'b0));
    localparam logic [SW-1:0] NXT1 = SW'(kmp_next(gi, 1'b1));
    assign nxt0_tab[gi] = NXT0;
    assign nxt1_tab[gi] = NXT1;
  end

  logic [SW-1:0]    st_q,    st_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    y       = rst & en & (st_q == LAST_ST) & (x == PATTERN[0]);
    st_d    = st_q;
    count_d = count_q;
    if (en) begin
      if (y) begin
        st_d = overlap ? F_ST : '0;
      end else begin
        st_d = x ? nxt1_tab[st_q] : nxt0_tab[st_q];
      end
    end
    if (y && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= '0;
      count_q <= '0;
    end else begin
      st_q    <= st_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: default 11011 detector, a 2-bit
// counter variant and a 4-bit 1010 variant share one stimulus bus.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       x;
  logic       overlap;
  logic       y_a, y_s, y_l;
  logic [7:0] cnt_a;
  logic [1:0] cnt_s;
  logic [7:0] cnt_l;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .y(y_a), .count(cnt_a)
  );

  seq_detector_param #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .y(y_s), .count(cnt_s)
  );

  seq_detector_param #(.N(4), .PATTERN(4'b1010)) dut_alt (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .y(y_l), .count(cnt_l)
  );

  typedef struct {
    string tag;
    int    sel;
    logic  exp_y;
    int    exp_cnt;
  } sb_t;

  sb_t sb_q[$];
  sb_t cur;
  bit  pend = 1'b0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic pick_y(input int sel);
    case (sel)
      0:       return y_a;
      1:       return y_s;
      default: return y_l;
    endcase
  endfunction

  function automatic logic [31:0] pick_cnt(input int sel);
    case (sel)
      0:       return 32'(cnt_a);
      1:       return 32'(cnt_s);
      default: return 32'(cnt_l);
    endcase
  endfunction

  // y is checked just before the consuming edge, count at the following negedge.
  always @(negedge clk) begin
    if (pend) begin
      check({cur.tag, "_cnt"}, pick_cnt(cur.sel), 32'(cur.exp_cnt));
      pend = 1'b0;
    end
    #4;
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      $display("[TB] %s sel=%0d en=%0b x=%0b ov=%0b y=%0b exp_y=%0b exp_cnt=%0d",
               cur.tag, cur.sel, en, x, overlap, pick_y(cur.sel), cur.exp_y, cur.exp_cnt);
      check({cur.tag, "_y"}, 32'(pick_y(cur.sel)), 32'(cur.exp_y));
      pend = 1'b1;
    end
  end

  // bits: first-arriving bit is bits[len-1]; mask[i-1] marks a match on bit i.
  task automatic run_stream(input string tag, input int sel, input logic ov, input logic e,
                            input logic [31:0] bits, input int len,
                            input logic [31:0] mask, input int cmax);
    for (int i = 1; i <= len; i++) begin
      logic m;
      m = mask[i-1];
      if (m && exp_cnt < cmax) exp_cnt++;
      overlap = ov;
      en      = e;
      x       = bits[len-i];
      sb_q.push_back('{tag, sel, m, exp_cnt});
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; x = 1'b1; overlap = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_y_a",   32'(y_a), 0);
    check("rst_y_s",   32'(y_s), 0);
    check("rst_y_l",   32'(y_l), 0);
    check("rst_cnt_a", 32'(cnt_a), 0);
    check("rst_cnt_s", 32'(cnt_s), 0);
    check("rst_cnt_l", 32'(cnt_l), 0);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);

    do_reset();
    run_stream("ovl0", 0, 1'b0, 1'b1, 32'b11011011, 8, 32'h90 & 32'h10, 255);
    do_reset();
    run_stream("ovl1", 0, 1'b1, 1'b1, 32'b11011011, 8, 32'h90, 255);

    do_reset();
    run_stream("kmp_a", 0, 1'b0, 1'b1, 32'b111, 3, 32'b0, 255);
    check("kmp_st3", 32'(dut.st_q), 2);
    run_stream("kmp_b", 0, 1'b0, 1'b1, 32'b011, 3, 32'b100, 255);

    do_reset();
    run_stream("en_a", 0, 1'b0, 1'b1, 32'b11, 2, 32'b0, 255);
    run_stream("en_hold", 0, 1'b0, 1'b0, 32'b000, 3, 32'b0, 255);
    check("en_hold_st", 32'(dut.st_q), 2);
    run_stream("en_b", 0, 1'b0, 1'b1, 32'b011, 3, 32'b100, 255);
    run_stream("en_c", 0, 1'b0, 1'b1, 32'b1101, 4, 32'b0, 255);
    run_stream("en_hold4", 0, 1'b0, 1'b0, 32'b11, 2, 32'b0, 255);
    check("en_hold4_st", 32'(dut.st_q), 4);
    run_stream("en_d", 0, 1'b0, 1'b1, 32'b1, 1, 32'b1, 255);

    do_reset();
    run_stream("rst_a", 0, 1'b0, 1'b1, 32'b110111101, 9, 32'b10000, 255);
    #1;
    en  = 1'b1;
    x   = 1'b1;
    rst = 1'b0;
    #2;
    check("rst_mid_y",   32'(y_a), 0);
    check("rst_mid_cnt", 32'(cnt_a), 0);
    check("rst_mid_st",  32'(dut.st_q), 0);
    #1;
    rst     = 1'b1;
    en      = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    run_stream("rst_b", 0, 1'b0, 1'b1, 32'b1, 1, 32'b0, 255);
    check("rst_b_st", 32'(dut.st_q), 1);

    do_reset();
    run_stream("sat", 1, 1'b1, 1'b1, 32'b11011011011011, 14, 32'h2490, 3);

    do_reset();
    run_stream("alt1", 2, 1'b1, 1'b1, 32'b101010, 6, 32'b101000, 255);
    do_reset();
    run_stream("alt0", 2, 1'b0, 1'b1, 32'b101010, 6, 32'b001000, 255);

    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy sequence detector, successor to the fixed non-overlapping 11011 detector. It recognises an arbitrary N-bit pattern on a serial bit stream and selects overlapping or non-overlapping detection at run time. It also has a sample-enable input and a saturating match counter. It sits on a single-bit serial input path and flags each match combinationally in the cycle the final pattern bit is presented.

## Interface

- N, 5: pattern length in bits; legal range 2..16.
- PATTERN, 5'b11011: pattern to detect. PATTERN[N-1] is the first bit received and PATTERN[0] is the last.
- CNT_W, 8: width of the match counter; legal range 1..32.

Ports:

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  sample enable; x is consumed only in cycles where en=1.
- x  in  1  serial data bit.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping detection.
- y  out  1  Mealy match flag, combinational from state, x, en and rst.
- count  out  CNT_W  number of matches since reset, saturating.

## Operation

- State register `st` ranges 0..N-1 and holds the number of pattern bits currently matched; it needs ceil(log2 N) bits.
- The expected next bit is PATTERN[N-1-st].
- y = rst & en & (st == N-1) & (x == PATTERN[0]).
- Match cycle (y=1):
  - overlap=1: next st = F, where F is the length of the longest proper prefix of PATTERN that is also a suffix of PATTERN.
  - overlap=0: next st = 0.
  - For 11011, F = 2.
- Non-match with en=1: next st = length of the longest prefix of PATTERN that is a suffix of (the matched prefix followed by x). This is full KMP fallback, not a reset to 0.
- Transition tables are computed at elaboration time by constant functions over PATTERN and N. There is no runtime table logic.
- en=0: st holds, y=0, count holds, and x is ignored.
- overlap is sampled every cycle. A change affects only the post-match transition of the cycle in which it is sampled; no state is flushed.
- count increments by 1 on each rising edge where y=1. At 2^CNT_W-1 it holds and does not wrap.
- Reset asserted: st=0, count=0, y=0 immediately, independent of clk.

## Timing

- Latency: y rises in the same cycle the last pattern bit is presented on x. It is valid before the rising edge that consumes that bit.
- count reflects a match one cycle after y=1, i.e. after the consuming edge.
- Reset is asynchronous assert; release is sampled by clk. The first bit consumed after release is treated as bit 0 of a fresh stream.
- Reset mid-pattern discards the partial match. There is no carry-over.
- Simultaneous match and saturation: y=1 and count stays at its maximum.
- Back-to-back matches in overlap mode: minimum spacing is N-F cycles, i.e. 3 cycles for 11011. In non-overlap mode the minimum spacing is N cycles.

## Test plan

Defaults apply unless noted; bits are listed in arrival order.

- Overlap vs non-overlap: apply stream 1,1,0,1,1,0,1,1 with en=1.
  - overlap=0: y=1 only on bit 5; count=1.
  - overlap=1: y=1 on bits 5 and 8; count=2.
- KMP fallback: apply stream 1,1,1,0,1,1 with overlap=0.
  - y=1 only on bit 6; count=1.
  - st after bit 3 is 2.
- Enable hold: apply bits 1,1, then en=0 for 3 cycles with x=0, then en=1 with bits 0,1,1.
  - y=0 during the hold cycles.
  - y=1 on the final bit; count=1.
- Reset mid-operation: apply 1,1,0,1, pulse rst low for half a cycle between edges, then apply 1.
  - y=0 throughout; count=0; st=1 after the final edge.
  - y and count read 0 while rst is low.
- Saturation: set CNT_W=2, overlap=1, and apply stream 11011011011011.
  - y=1 on bits 5, 8, 11 and 14.
  - count progresses 1, 2, 3, 3.
- Alternate pattern: set N=4, PATTERN=4'b1010 (F=2), and apply stream 1,0,1,0,1,0.
  - overlap=1: y=1 on bits 4 and 6.
  - overlap=0: y=1 on bit 4 only.
